regfile_writeback_queue: RTL and testbench
==========================================

Name: regfile_writeback_queue

Overview:
- Buffers register writeback requests from the execute and load units and drains them, one per cycle and in order, into the general regfile's single write port (write, write_reg_num, write_data).
- Provides a bypass lookup so operand-read logic can see data that is still queued and not yet committed to the regfile.
- Sits between the result producers and the regfile write port.

Parameters:
- DEPTH, 4, number of queued writeback entries; power of two, at least 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enq_valid  input  1  producer presents a writeback request.
- enq_ready  output  1  queue can accept a request this cycle.
- enq_reg  input  3  destination register number.
- enq_data  input  16  value to write.
- drain_hold  input  1  when high, inhibits draining. Used during regfile-side stalls and debug.
- write  output  1  regfile write enable.
- write_reg_num  output  3  regfile write address.
- write_data  output  16  regfile write data.
- query_reg_one  input  3  first operand register to check.
- query_reg_two  input  3  second operand register to check.
- hit_one  output  1  a queued entry targets query_reg_one.
- hit_data_one  output  16  data of the youngest such entry; 0 when no hit.
- hit_two  output  1  same as hit_one, for query_reg_two.
- hit_data_two  output  16  same as hit_data_one, for query_reg_two.
- count  output  PTR_W+1  current occupancy, 0 to DEPTH.

Behaviour:
- Only clk and reset are sequential controls. Reset is sampled on the rising clk edge and clears head, tail, count and all entry valid bits. Entry data need not be cleared.
- Reset values after a reset edge: enq_ready=1, write=0, write_reg_num=0, write_data=0, hit_one=0, hit_two=0, hit_data_one=0, hit_data_two=0, count=0.
- Reset asserted mid-operation discards all queued entries; no write is issued on that edge or on the following cycle.
- Enqueue fires when enq_valid and enq_ready are both high at the clock edge. The entry is stored at tail, and tail increments modulo DEPTH.
- enq_ready = (count != DEPTH). It does not depend on a same-cycle dequeue.
- Drain is combinational from the head entry:
  - write = (count != 0) and not drain_hold.
  - write_reg_num and write_data come from the head entry when write is high; both are 0 otherwise.
- Dequeue occurs on every edge where write is high; head increments modulo DEPTH. The regfile always accepts, so there is no ready signal from it.
- Minimum latency is one cycle: a request accepted at edge N appears on write at cycle N+1 if the queue was empty.
- Ordering: strictly FIFO. Two queued writes to the same register commit oldest first.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance. This is legal at any count from 1 to DEPTH-1.
- Full (count=DEPTH): enqueue is blocked even if a dequeue happens in the same cycle. The count drops to DEPTH-1 at that edge.
- Empty (count=0): write=0 and no dequeue. An enqueue in that cycle is not visible on write until the next cycle; there is no fall-through.
- Pointer wrap: after index DEPTH-1 the pointer returns to 0. count disambiguates full from empty.
- Bypass is combinational:
  - It scans only the valid entries.
  - The youngest matching entry (nearest tail) wins.
  - The head entry being written this cycle still counts as a hit, because the regfile updates only at the edge.
  - An entry being enqueued this same cycle is not yet visible to bypass.
- drain_hold high: the queue retains its contents, write=0, enqueue continues until full, and bypass remains active.

Test Plan:
- Reset, then idle -> count=0, enq_ready=1, write=0, hit_one=0.
- Enqueue (r3, 0x1234) on an empty queue -> next cycle write=1, write_reg_num=3, write_data=0x1234; the cycle after, count=0 and write=0.
- drain_hold=1 while enqueuing r1=0x0001, r2=0x0002, r3=0x0003, r4=0x0004 -> count=4, enq_ready=0, and a fifth request is not accepted. Release drain_hold -> writes r1, r2, r3, r4 in four consecutive cycles.
- drain_hold=1, enqueue r5=0xAAAA then r5=0xBBBB, query_reg_one=5 -> hit_one=1, hit_data_one=0xBBBB; query_reg_two=6 -> hit_two=0, hit_data_two=0.
- Continuous enqueue every cycle for 10 cycles with drain_hold=0, regs 0..7 cycling, data 0x0100+i -> count stays at 1 after the first cycle, pointers wrap, and the write sequence matches the input order exactly.
- Fill to 3 entries, assert reset for one edge -> count=0, write=0, and no write is issued; a subsequent enqueue of (r7, 0xFFFF) drains correctly.

Source files
------------

// File: rtl/regfile_writeback_queue.sv
// ============================================================================
// Module   : regfile_writeback_queue
// Purpose  : In-order writeback FIFO feeding the regfile write port, with
//            youngest-entry bypass lookup for two operand queries.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [2:0]       enq_reg,
  input  logic [15:0]      enq_data,
  input  logic             drain_hold,
  output logic             write,
  output logic [2:0]       write_reg_num,
  output logic [15:0]      write_data,
  input  logic [2:0]       query_reg_one,
  input  logic [2:0]       query_reg_two,
  output logic             hit_one,
  output logic [15:0]      hit_data_one,
  output logic             hit_two,
  output logic [15:0]      hit_data_two,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   occ;
  logic             enq_fire;
  logic             deq_fire;

  logic [DEPTH-1:0] entry_valid;
  logic [2:0]       entry_reg  [DEPTH];
  logic [15:0]      entry_data [DEPTH];

  assign count     = occ;
  assign enq_ready = (occ != FULL_COUNT);
  assign enq_fire  = enq_valid && enq_ready;

  // Reset is folded into write so nothing reaches the regfile on a reset edge.
  assign write    = (occ != '0) && !drain_hold && !reset;
  assign deq_fire = write;

  assign write_reg_num = write ? entry_reg[head]  : 3'd0;
  assign write_data    = write ? entry_data[head] : 16'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (enq_fire) tail <= tail + PTR_W'(1);
      if (deq_fire) head <= head + PTR_W'(1);
      case ({enq_fire, deq_fire})
        2'b10:   occ <= occ + (PTR_W + 1)'(1);
        2'b01:   occ <= occ - (PTR_W + 1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic        vld;
      logic [2:0]  rnum;
      logic [15:0] dat;
      logic        wr_here;
      logic        rd_here;

      assign wr_here = enq_fire && (tail == PTR_W'(i));
      assign rd_here = deq_fire && (head == PTR_W'(i));

      // Set and clear never target the same slot: that would need full and empty at once.
      always_ff @(posedge clk) begin
        if (reset) begin
          vld <= 1'b0;
        end else if (wr_here) begin
          vld <= 1'b1;
        end else if (rd_here) begin
          vld <= 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (wr_here) begin
          rnum <= enq_reg;
          dat  <= enq_data;
        end
      end

      assign entry_valid[i] = vld;
      assign entry_reg[i]   = rnum;
      assign entry_data[i]  = dat;
    end
  endgenerate

  // Walk from oldest to youngest so the last match (nearest tail) wins.
  logic [PTR_W-1:0] scan_idx;

  always_comb begin
    hit_one      = 1'b0;
    hit_data_one = 16'd0;
    hit_two      = 1'b0;
    hit_data_two = 16'd0;
    scan_idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head + PTR_W'(k);
      if (entry_valid[scan_idx] && (entry_reg[scan_idx] == query_reg_one)) begin
        hit_one      = 1'b1;
        hit_data_one = entry_data[scan_idx];
      end
      if (entry_valid[scan_idx] && (entry_reg[scan_idx] == query_reg_two)) begin
        hit_two      = 1'b1;
        hit_data_two = entry_data[scan_idx];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback_queue.sv
// ============================================================================
// Module   : tb_regfile_writeback_queue
// Purpose  : Directed scoreboard bench for regfile_writeback_queue.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_regfile_writeback_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  typedef struct packed {
    logic [2:0]  r;
    logic [15:0] d;
  } wb_t;

  logic        clk;
  logic        reset;
  logic        enq_valid;
  logic        enq_ready;
  logic [2:0]  enq_reg;
  logic [15:0] enq_data;
  logic        drain_hold;
  logic        write;
  logic [2:0]  write_reg_num;
  logic [15:0] write_data;
  logic [2:0]  query_reg_one;
  logic [2:0]  query_reg_two;
  logic        hit_one;
  logic [15:0] hit_data_one;
  logic        hit_two;
  logic [15:0] hit_data_two;
  logic [PTR_W:0] count;

  int  checks = 0;
  int  errors = 0;
  wb_t sb[$];

  regfile_writeback_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .enq_valid     (enq_valid),
    .enq_ready     (enq_ready),
    .enq_reg       (enq_reg),
    .enq_data      (enq_data),
    .drain_hold    (drain_hold),
    .write         (write),
    .write_reg_num (write_reg_num),
    .write_data    (write_data),
    .query_reg_one (query_reg_one),
    .query_reg_two (query_reg_two),
    .hit_one       (hit_one),
    .hit_data_one  (hit_data_one),
    .hit_two       (hit_two),
    .hit_data_two  (hit_data_two),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare at the falling edge, then update the model.
  task automatic cycle(input logic en, input logic [2:0] r, input logic [15:0] d,
                       input logic hold, input logic rst);
    logic        exp_ready;
    logic        exp_write;
    logic        eh1, eh2;
    logic [15:0] ed1, ed2;
    wb_t         front;
    enq_valid  = en;
    enq_reg    = r;
    enq_data   = d;
    drain_hold = hold;
    reset      = rst;
    @(negedge clk);
    exp_ready = (sb.size() != DEPTH);
    exp_write = (sb.size() != 0) && !hold && !rst;
    eh1 = 1'b0; ed1 = 16'd0;
    eh2 = 1'b0; ed2 = 16'd0;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].r == query_reg_one) begin eh1 = 1'b1; ed1 = sb[i].d; end
      if (sb[i].r == query_reg_two) begin eh2 = 1'b1; ed2 = sb[i].d; end
    end
    front = (sb.size() != 0) ? sb[0] : '0;
    check("count",     32'(count),     32'(sb.size()));
    check("enq_ready", 32'(enq_ready), 32'(exp_ready));
    check("write",     32'(write),     32'(exp_write));
    check("write_reg_num", 32'(write_reg_num), exp_write ? 32'(front.r) : 32'd0);
    check("write_data",    32'(write_data),    exp_write ? 32'(front.d) : 32'd0);
    check("hit_one",      32'(hit_one),      32'(eh1));
    check("hit_data_one", 32'(hit_data_one), 32'(ed1));
    check("hit_two",      32'(hit_two),      32'(eh2));
    check("hit_data_two", 32'(hit_data_two), 32'(ed2));
    if (rst) begin
      sb.delete();
    end else begin
      if (exp_write) void'(sb.pop_front());
      if (en && exp_ready) sb.push_back('{r: r, d: d});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    enq_valid     = 1'b0;
    enq_reg       = 3'd0;
    enq_data      = 16'd0;
    drain_hold    = 1'b0;
    query_reg_one = 3'd0;
    query_reg_two = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle after reset
    cycle(1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
    cycle(1'b0, 3'd0, 16'd0, 1'b0, 1'b0);

    // Single entry, one-cycle latency
    query_reg_one = 3'd3;
    cycle(1'b1, 3'd3, 16'h1234, 1'b0, 1'b0);
    cycle(1'b0, 3'd0, 16'd0,    1'b0, 1'b0);
    cycle(1'b0, 3'd0, 16'd0,    1'b0, 1'b0);

    // Fill under hold, reject fifth, then drain in order
    query_reg_one = 3'd2;
    query_reg_two = 3'd4;
    for (int i = 1; i <= 4; i++) cycle(1'b1, 3'(i), 16'(i), 1'b1, 1'b0);
    cycle(1'b1, 3'd5, 16'h0005, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 3'd0, 16'd0, 1'b0, 1'b0);

    // Youngest-match bypass under hold
    query_reg_one = 3'd5;
    query_reg_two = 3'd6;
    cycle(1'b1, 3'd5, 16'hAAAA, 1'b1, 1'b0);
    cycle(1'b1, 3'd5, 16'hBBBB, 1'b1, 1'b0);
    cycle(1'b0, 3'd0, 16'd0,    1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 16'd0, 1'b0, 1'b0);

    // Streaming enqueue with concurrent drain, pointers wrap
    query_reg_one = 3'd2;
    query_reg_two = 3'd7;
    for (int i = 0; i < 10; i++) cycle(1'b1, 3'(i % 8), 16'h0100 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 3'd0, 16'd0, 1'b0, 1'b0);

    // Reset mid-operation discards entries
    query_reg_one = 3'd1;
    query_reg_two = 3'd7;
    cycle(1'b1, 3'd1, 16'h1111, 1'b1, 1'b0);
    cycle(1'b1, 3'd2, 16'h2222, 1'b1, 1'b0);
    cycle(1'b1, 3'd6, 16'h6666, 1'b1, 1'b0);
    cycle(1'b0, 3'd0, 16'd0,    1'b0, 1'b1);
    cycle(1'b0, 3'd0, 16'd0,    1'b0, 1'b0);
    cycle(1'b1, 3'd7, 16'hFFFF, 1'b0, 1'b0);
    cycle(1'b0, 3'd0, 16'd0,    1'b0, 1'b0);
    cycle(1'b0, 3'd0, 16'd0,    1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
